// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider.
//   DIV_MIN     : smallest divisor that can be loaded at runtime.
//   run_state_e : run/stop state of the divider.
//   hlen()      : number of whole posedge cycles that hi_p stays high for divisor n.
package clkdiv_pkg;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic {
    StStop,
    StRun
  } run_state_e;

  // Odd divisors get their extra half cycle from the negedge stretch flop,
  // so the posedge high phase is one shorter than n/2 rounded up.
  function automatic int unsigned hlen(input int unsigned n);
    if (n[0]) begin
      return (n - 1) / 2;
    end else begin
      return n / 2;
    end
  endfunction

endpackage

// File: rtl/frequency_divider_prog_if.sv
// Control/status bundle of the programmable clock divider.
//   en        : run enable (master -> slave)
//   div_load  : one-cycle strobe requesting a new divisor (master -> slave)
//   div_in    : requested divisor (master -> slave)
//   clk_out   : divided 50%-duty clock (slave -> master)
//   tick      : one-cycle strobe at each output period start (slave -> master)
//   div_cur   : divisor currently in effect (slave -> master)
//   div_err   : sticky illegal-divisor flag (slave -> master)
interface frequency_divider_prog_if #(
  parameter int unsigned W = 8
);

  logic         en;
  logic         div_load;
  logic [W-1:0] div_in;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] div_cur;
  logic         div_err;

  modport master (
    output en,
    output div_load,
    output div_in,
    input  clk_out,
    input  tick,
    input  div_cur,
    input  div_err
  );

  modport slave (
    input  en,
    input  div_load,
    input  div_in,
    output clk_out,
    output tick,
    output div_cur,
    output div_err
  );

endinterface

// File: rtl/clkdiv_neg_stretch.sv
// Negedge half-cycle stretcher for odd divisors. The only negedge logic of the
// divider lives here so it can be constrained on its own.
//   clk_i     : input clock (flop uses its falling edge)
//   rst_i     : synchronous active-high clear, sampled on the falling edge
//   hi_p_i    : posedge-domain high phase
//   gate_i    : 1 while running with an odd divisor
//   stretch_o : hi_p delayed by half a cycle, forced low when gate_i is 0
module clkdiv_neg_stretch (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hi_p_i,
  input  logic gate_i,
  output logic stretch_o
);

  logic hi_n_q;
  logic hi_n_d;

  always_comb begin
    hi_n_d = hi_p_i;
  end

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      hi_n_q <= 1'b0;
    end else begin
      hi_n_q <= hi_n_d;
    end
  end

  assign stretch_o = hi_n_q & gate_i;

endmodule

// File: rtl/frequency_divider_prog.sv
// Runtime-programmable integer clock divider producing a 50%-duty clk_out at
// clk/N (2 <= N <= 2^W-1) plus a one-cycle tick at each output period start.
// New divisors are held pending and only take effect at a period boundary, so
// clk_out never shows a runt pulse except when rst cuts a period short.
//   W       : divisor width
//   DIV_RST : divisor in effect after reset (>= 2)
//   clk     : input clock
//   rst     : synchronous active-high reset
//   bus_io  : control/status bundle (en, div_load, div_in, clk_out, tick,
//             div_cur, div_err)
module frequency_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned DIV_RST = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  frequency_divider_prog_if.slave bus_io
);

  localparam logic [W-1:0] DivRst = W'(DIV_RST);
  localparam logic [W-1:0] DivMin = W'(DIV_MIN);
  localparam logic [W-1:0] One    = W'(1);

  run_state_e   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_cur_q, div_cur_d;
  logic [W-1:0] div_pend_q, div_pend_d;
  logic         pend_v_q, pend_v_d;
  logic         div_err_q, div_err_d;
  logic         hi_p_q, hi_p_d;
  logic         tick_q, tick_d;

  logic [W-1:0] last_cnt;
  logic [W-1:0] hlen_d;
  logic         wrap;
  logic         reload;
  logic         load_ok;
  logic         load_bad;
  logic         stretch;

  assign last_cnt = div_cur_q - One;
  assign wrap     = (state_q == StRun) && (cnt_q == last_cnt);
  // Period boundary: either the end of a running period or a start from stop.
  assign reload   = wrap || ((state_q == StStop) && bus_io.en);
  assign load_ok  = bus_io.div_load && (bus_io.div_in >= DivMin);
  assign load_bad = bus_io.div_load && (bus_io.div_in < DivMin);

  // Run/stop state: a running period always completes before stopping.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStop: begin
        if (bus_io.en) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (wrap && !bus_io.en) begin
          state_d = StStop;
        end
      end
    endcase
  end

  // Divisor bookkeeping, counter and waveform next-state.
  always_comb begin
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_v_d   = pend_v_q;
    div_err_d  = div_err_q;
    cnt_d      = cnt_q;
    hlen_d     = '0;
    hi_p_d     = 1'b0;
    tick_d     = 1'b0;

    if (reload && pend_v_q) begin
      div_cur_d = div_pend_q;
      pend_v_d  = 1'b0;
    end

    // Captured after the reload above, so a load on the boundary edge waits
    // for the next boundary.
    if (load_ok) begin
      div_pend_d = bus_io.div_in;
      pend_v_d   = 1'b1;
    end

    if (load_bad) begin
      div_err_d = 1'b1;
    end

    if (state_d == StStop) begin
      cnt_d = div_cur_d - One;
    end else if (reload) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + One;
    end

    hlen_d = W'(hlen(32'(div_cur_d)));
    hi_p_d = (state_d == StRun) && (cnt_d < hlen_d);
    tick_d = (state_d == StRun) && reload;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StStop;
      cnt_q      <= DivRst - One;
      div_cur_q  <= DivRst;
      div_pend_q <= DivRst;
      pend_v_q   <= 1'b0;
      div_err_q  <= 1'b0;
      hi_p_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_v_q   <= pend_v_d;
      div_err_q  <= div_err_d;
      hi_p_q     <= hi_p_d;
      tick_q     <= tick_d;
    end
  end

  // Gating with the run state makes clk_out drop right at a reset edge even
  // though the negedge flop only clears half a cycle later.
  clkdiv_neg_stretch u_neg_stretch (
    .clk_i     (clk),
    .rst_i     (rst),
    .hi_p_i    (hi_p_q),
    .gate_i    (div_cur_q[0] && (state_q == StRun)),
    .stretch_o (stretch)
  );

  assign bus_io.clk_out = hi_p_q | stretch;
  assign bus_io.tick    = tick_q;
  assign bus_io.div_cur = div_cur_q;
  assign bus_io.div_err = div_err_q;

endmodule

// File: tb/tb_frequency_divider_prog.sv
module tb_frequency_divider_prog;

  localparam int unsigned W       = 8;
  localparam int unsigned DIV_RST = 3;

  logic clk;
  logic rst;

  frequency_divider_prog_if #(.W(W)) bus ();

  frequency_divider_prog #(
    .W       (W),
    .DIV_RST (DIV_RST)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned errors;

  // Reference model: position within the current output period and the
  // divisor governing it. clk_out is high for the first N half-cycles of
  // every 2N half-cycle period.
  bit          m_run;
  bit          m_tick;
  bit          m_err;
  bit          m_pend_v;
  int unsigned m_n;
  int unsigned m_pos;
  int unsigned m_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_out(input int unsigned half);
    return m_run && ((2 * m_pos + half) < m_n);
  endfunction

  task automatic model_step(input bit r, input bit e, input bit ld, input int unsigned d);
    if (r) begin
      m_n      = DIV_RST;
      m_run    = 1'b0;
      m_pos    = 0;
      m_pend_v = 1'b0;
      m_err    = 1'b0;
      m_tick   = 1'b0;
    end else begin
      m_tick = 1'b0;
      if (!m_run || (m_pos == m_n - 1)) begin
        // period boundary (end of period, or start from stop)
        if ((m_run || e) && m_pend_v) begin
          m_n      = m_pend;
          m_pend_v = 1'b0;
        end
        if (e) begin
          m_run  = 1'b1;
          m_pos  = 0;
          m_tick = 1'b1;
        end else begin
          m_run = 1'b0;
        end
      end else begin
        m_pos++;
      end
      if (ld) begin
        if (d >= 2) begin
          m_pend   = d;
          m_pend_v = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit ld, input int unsigned d);
    rst          = r;
    bus.en       = e;
    bus.div_load = ld;
    bus.div_in   = W'(d);
    @(posedge clk);
    model_step(r, e, ld, d);
    #1;
    check_eq("tick", bus.tick, m_tick);
    check_eq("div_cur", bus.div_cur, m_n);
    check_eq("div_err", bus.div_err, m_err);
    check_eq("clk_out_pos", bus.clk_out, exp_out(0));
    @(negedge clk);
    #1;
    check_eq("clk_out_neg", bus.clk_out, exp_out(1));
  endtask

  task automatic run_until_tick_n(input int unsigned n, input int unsigned limit);
    int unsigned i = 0;
    while (!(bus.tick === 1'b1 && bus.div_cur == W'(n)) && i < limit) begin
      step(1'b0, 1'b1, 1'b0, 0);
      i++;
    end
    check_eq("wait_tick", bus.tick, 1);
    check_eq("wait_div", bus.div_cur, n);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;

    // reset, then default divide-by-3
    repeat (3) step(1'b1, 1'b1, 1'b0, 0);
    repeat (12) step(1'b0, 1'b1, 1'b0, 0);

    // even reload mid-period
    step(1'b0, 1'b1, 1'b1, 4);
    repeat (12) step(1'b0, 1'b1, 1'b0, 0);

    // last load before the wrap wins
    run_until_tick_n(4, 10);
    step(1'b0, 1'b1, 1'b1, 7);
    step(1'b0, 1'b1, 1'b1, 6);
    repeat (16) step(1'b0, 1'b1, 1'b0, 0);

    // largest odd divisor
    step(1'b0, 1'b1, 1'b1, 255);
    run_until_tick_n(255, 20);
    repeat (300) step(1'b0, 1'b1, 1'b0, 0);

    // illegal divisors
    step(1'b0, 1'b1, 1'b1, 1);
    step(1'b0, 1'b1, 1'b1, 0);
    repeat (4) step(1'b0, 1'b1, 1'b0, 0);

    // stop at cnt=1 of N=5, then restart
    step(1'b0, 1'b1, 1'b1, 5);
    run_until_tick_n(5, 300);
    step(1'b0, 1'b1, 1'b0, 0);
    repeat (8) step(1'b0, 1'b0, 1'b0, 0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 0);

    // reset while clk_out is high
    run_until_tick_n(5, 10);
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit          r;
      bit          e;
      bit          ld;
      int unsigned d;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 5) == 0);
      d  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
      step(r, e, ld, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frequency_divider_prog.md
# frequency_divider_prog

Runtime-programmable integer clock divider. It produces a 50%-duty `clk_out` at `clk`/N for any N from 2 to 2^W-1, odd or even. It also produces a one-cycle `tick` enable in the `clk` domain. It generalises the fixed divide-by-3 block, adding divisor reload at period boundaries, a run/stop enable and illegal-divisor detection, and serves as the clock/strobe source for slower peripheral logic.

## Interface
- `W`, 8: divisor width in bits.
- `DIV_RST`, 3: divisor loaded on reset; must be ≥ 2.
- `clk` in 1: input clock. Both edges are used internally.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable.
- `div_load` in 1: single-cycle strobe that requests a new divisor.
- `div_in` in W: requested divisor N.
- `clk_out` out 1: divided clock.
- `tick` out 1: one-`clk`-cycle pulse at the start of each output period.
- `div_cur` out W: divisor currently in effect.
- `div_err` out 1: sticky flag; set when an illegal load is requested.

## Operation
- **Registers:**
  - `cnt[W-1:0]`: counter, updated on posedge.
  - `div_cur`: active divisor.
  - `div_pend` plus `pend_v`: pending divisor and its valid bit.
  - `hi_p`: posedge-domain high phase.
  - `hi_n`: negedge copy of `hi_p`.
  - `run`: running state.
- **Reset (while `rst`=1 at a posedge):**
  - `cnt` = `div_cur`-1 with `div_cur` = `DIV_RST`.
  - `pend_v`=0, `div_err`=0, `run`=0, `hi_p`=0.
  - `hi_n` clears at the next negedge.
  - Resulting outputs: `clk_out`=0, `tick`=0, `div_cur`=`DIV_RST`.
- **State `run`:**
  - STOP→RUN: at a posedge where `en`=1.
  - RUN→STOP: only at the wrap posedge (`cnt`==`div_cur`-1) with `en`=0. The current period always completes.
  - In STOP: `cnt` is held at `div_cur`-1 and `clk_out`/`tick` stay 0.
- **Counting (RUN):**
  - `cnt` increments each posedge.
  - At `cnt`==`div_cur`-1 it wraps to 0.
  - The cycle in which `cnt`==0 follows a wrap is the period start.
- **Divisor load:**
  - `div_load`=1 with `div_in` ≥ 2: `div_pend` ← `div_in`, `pend_v` ← 1. A later load before the wrap overwrites it (last one wins).
  - `div_load`=1 with `div_in` < 2: ignored; `div_err` ← 1. `div_err` clears only on `rst`.
  - At a wrap with `pend_v`=1, or at STOP→RUN with `pend_v`=1: `div_cur` ← `div_pend` and `pend_v` ← 0. The new N governs that new period from `cnt`=0.
  - A load on the same posedge as the wrap is captured and takes effect at the following wrap.
- **Waveform, N even:**
  - `hi_p` (registered) = 1 for `cnt` ∈ [0, N/2-1].
  - `clk_out` = `hi_p`.
- **Waveform, N odd:**
  - `hi_p` = 1 for `cnt` ∈ [0, (N-3)/2].
  - `hi_n` samples `hi_p` on negedge.
  - `clk_out` = `hi_p` | `hi_n`, giving a high time of N/2 input periods.
  - `hi_n` is forced 0 when `div_cur` is even.
- **Tick:** `tick` = RUN && `cnt`==0 after a wrap or start (registered, aligned to the rising edge of `clk_out`).

## Timing
- `en` sampled 1 at posedge k (from STOP): `cnt`=0, `tick`=1 and `clk_out` rises after posedge k. This is 1-cycle start latency.
- Period is exactly N `clk` cycles. There are no runt pulses on reload, start or stop, because changes occur only at period boundaries with `clk_out` low.
- Odd N: `clk_out` falls on the negedge in the middle of cycle (N-1)/2. Even N: it falls on the posedge ending cycle N/2-1.
- `rst` mid-period: `clk_out` and `tick` are 0 after that posedge. A runt high of less than N/2 is permitted only at reset.
- `div_cur` updates in the same cycle as `tick`.
- `div_err` asserts 1 cycle after the illegal `div_load`.

## Structure
- Shared package `clkdiv_pkg`: constant `DIV_MIN`=2; function computing the high-phase length `hlen(N)` = N/2 for even N, (N-1)/2 for odd N.
- One sub-module, `clkdiv_neg_stretch`:
  - negedge flop with synchronous clear on `rst`, plus the odd-gate;
  - this isolates the only negedge logic for synthesis/STA constraints.
- All other logic sits on posedge `clk`.

## Test plan
- **Reset/default:** `DIV_RST`=3, `rst` held then released with `en`=1 → period 3 `clk` cycles, `clk_out` high 1.5 cycles; `tick` every 3rd cycle; `div_cur`=3.
- **Even reload:** load 4 mid-period → current N=3 period completes; the next period is 4 cycles high 2 / low 2, and `div_cur`=4 coincides with `tick`.
- **Odd large and last-wins:** load 7, then load 6 before the wrap → first new period N=6. Then load 255 (W=8) → high 127.5 cycles, period 255.
- **Illegal divisors:** `div_in`=1, then `div_in`=0 → `div_err`=1 from the next cycle; `div_cur` unchanged; waveform undisturbed; `div_err` stays 1 until `rst`.
- **Stop/start:** deassert `en` at `cnt`=1 of N=5 → the period completes, then `clk_out`=0 and `tick`=0. Reassert `en` → `tick`+rise 1 cycle later.
- **Reset mid-high:** `rst` during `clk_out`=1 with N=5 → `clk_out`=0 after that posedge (`hi_n` clear by the next negedge), and `div_cur`=`DIV_RST`.
